// File: rtl/fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-domain controller of the dual-clock FIFO. Synchronizes the Gray write
// pointer from the write clock domain and derives empty from it. Maintains the
// binary and Gray read pointers and issues read strobes to fifo_mem. Read data
// is presented on a valid/ready stream through a 2-entry output buffer, which
// sustains one word per cycle.
//
// Optional build macro: FIFO_RD_LEVEL_EN
//   Adds the rd_level output: the registered count of words in memory as seen
//   from the read domain. Words already held in the output buffer are not
//   counted.
//
// Ports
//   clk_r         in   read-domain clock
//   arst_n        in   asynchronous active-low reset
//   g_wptr_async  in   Gray write pointer from clk_w domain (unsynchronized)
//   b_rptr        out  binary read pointer to fifo_mem
//   g_rptr        out  registered Gray read pointer to write-domain sync
//   r_en          out  read strobe to fifo_mem
//   empty         out  FIFO empty, to fifo_mem
//   mem_data      in   fifo_mem read data, valid the cycle after r_en
//   m_data        out  stream data (head of output buffer)
//   m_valid       out  stream valid
//   m_ready       in   stream ready from consumer
//   rd_level      out  (FIFO_RD_LEVEL_EN only) words in memory, read view
// ---------------------------------------------------------------------------
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    localparam int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk_r,
    input  logic                  arst_n,
    input  logic [PTR_WIDTH:0]    g_wptr_async,
    output logic [PTR_WIDTH:0]    b_rptr,
    output logic [PTR_WIDTH:0]    g_rptr,
    output logic                  r_en,
    output logic                  empty,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [PTR_WIDTH:0]    rd_level
`endif
);

    localparam int PW = PTR_WIDTH + 1;

    // Synchronizer chain as one packed shift register: newest stage in the
    // low slice, the synchronized pointer in the top slice.
    logic [SYNC_STAGES*PW-1:0] r_sync;
    logic [PTR_WIDTH:0]        w_wptr_s;

    logic [PTR_WIDTH:0]        r_b_rptr;
    logic [PTR_WIDTH:0]        r_g_rptr;
    logic [PTR_WIDTH:0]        w_b_next;
    logic [PTR_WIDTH:0]        w_g_next;

    logic [DATA_WIDTH-1:0]     r_buf [2];
    logic                      r_wr_idx;
    logic                      r_rd_idx;
    logic [1:0]                r_occ;
    logic                      r_infl;

    logic                      w_empty;
    logic                      w_pop;
    logic [2:0]                w_pending;
    logic                      w_r_en;

    always_ff @(posedge clk_r or negedge arst_n) begin
        if (!arst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[(SYNC_STAGES-1)*PW-1:0], g_wptr_async};
        end
    end

    assign w_wptr_s = r_sync[SYNC_STAGES*PW-1 -: PW];

    always_comb begin
        w_empty   = (r_g_rptr == w_wptr_s);
        w_pop     = (r_occ != 2'd0) && m_ready;
        // Words the buffer will hold after this edge if no new read is
        // issued: current occupancy plus the word landing now, minus a pop.
        w_pending = {1'b0, r_occ} + {2'b00, r_infl} - {2'b00, w_pop};
        w_r_en    = !w_empty && (w_pending < 3'd2);
        w_b_next  = r_b_rptr + 1'b1;
        w_g_next  = w_b_next ^ (w_b_next >> 1);
    end

    always_ff @(posedge clk_r or negedge arst_n) begin
        if (!arst_n) begin
            r_b_rptr <= '0;
            r_g_rptr <= '0;
            r_infl   <= 1'b0;
        end else begin
            r_infl <= w_r_en;
            if (w_r_en) begin
                r_b_rptr <= w_b_next;
                r_g_rptr <= w_g_next;
            end
        end
    end

    // Output buffer: the word requested last cycle is on mem_data now and is
    // captured into the tail; a pop advances the head. Both may happen on the
    // same edge, leaving occupancy unchanged.
    always_ff @(posedge clk_r or negedge arst_n) begin
        if (!arst_n) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_wr_idx <= 1'b0;
            r_rd_idx <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (r_infl) begin
                r_buf[r_wr_idx] <= mem_data;
                r_wr_idx        <= ~r_wr_idx;
            end
            if (w_pop) begin
                r_rd_idx <= ~r_rd_idx;
            end
            r_occ <= r_occ + {1'b0, r_infl} - {1'b0, w_pop};
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
        logic [PTR_WIDTH:0] b;
        b = g;
        for (int unsigned i = 1; i <= PTR_WIDTH; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    logic [PTR_WIDTH:0] r_rd_level;

    always_ff @(posedge clk_r or negedge arst_n) begin
        if (!arst_n) begin
            r_rd_level <= '0;
        end else begin
            r_rd_level <= gray2bin(w_wptr_s) - r_b_rptr;
        end
    end

    assign rd_level = r_rd_level;
`endif

    assign b_rptr  = r_b_rptr;
    assign g_rptr  = r_g_rptr;
    assign r_en    = w_r_en;
    assign empty   = w_empty;
    assign m_data  = r_buf[r_rd_idx];
    assign m_valid = (r_occ != 2'd0);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_ctrl
// Directed bench for fifo_rd_ctrl with a behavioural write side and fifo_mem.
// Written words are pushed to a scoreboard queue and popped when the stream
// delivers a beat.
// ---------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int PW    = 3;

    logic          clk_r        = 1'b0;
    logic          arst_n       = 1'b1;
    logic [PW:0]   g_wptr_async = '0;
    logic [PW:0]   b_rptr;
    logic [PW:0]   g_rptr;
    logic          r_en;
    logic          empty;
    logic [DW-1:0] mem_data     = '0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready      = 1'b0;
`ifdef FIFO_RD_LEVEL_EN
    logic [PW:0]   rd_level;
`endif

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [PW:0]   wptr = '0;

    int   n_checks   = 0;
    int   n_fail     = 0;
    int   r_en_count = 0;
    logic wrap_seen  = 1'b0;
    logic [PW:0] prev_b = '0;

    fifo_rd_ctrl #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk_r        (clk_r),
        .arst_n       (arst_n),
        .g_wptr_async (g_wptr_async),
        .b_rptr       (b_rptr),
        .g_rptr       (g_rptr),
        .r_en         (r_en),
        .empty        (empty),
        .mem_data     (mem_data),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .rd_level     (rd_level)
`endif
    );

    always #5 clk_r = ~clk_r;

    // fifo_mem read port: registered read, data valid the cycle after r_en.
    always @(posedge clk_r) begin
        if (r_en && !empty) mem_data <= mem[b_rptr[PW-1:0]];
    end

    always @(posedge clk_r) begin
        if (arst_n && r_en) r_en_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard and invariants, sampled mid-cycle.
    always @(negedge clk_r) begin
        if (arst_n === 1'b1) begin
            check("rd_when_empty", {31'b0, r_en & empty}, 32'd0);
            check("gray_rptr", {28'b0, g_rptr}, {28'b0, b_rptr ^ (b_rptr >> 1)});
            if (prev_b == 4'd15 && b_rptr == 4'd0) wrap_seen = 1'b1;
            prev_b = b_rptr;
            if (m_valid && m_ready) begin
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_beat: observed data 0x%0h expected no beat", m_data);
                end
                if (exp_q.size() != 0) begin
                    check("beat_data", {24'b0, m_data}, {24'b0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_r);
            #1;
        end
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        mem[wptr[PW-1:0]] = d;
        exp_q.push_back(d);
        wptr         = wptr + 1'b1;
        g_wptr_async = wptr ^ (wptr >> 1);
    endtask

    task automatic wait_idle(input int max);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || m_valid) && k < max) begin
            tick(1);
            k++;
        end
        check("drain_left", exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_cnt;
        int k;
        logic [PW:0] base_b;

        // Asynchronous reset assertion, checked before any clock edge.
        #1 arst_n = 1'b0;
        #1;
        check("rst_b_rptr",  {28'b0, b_rptr},  32'd0);
        check("rst_g_rptr",  {28'b0, g_rptr},  32'd0);
        check("rst_empty",   {31'b0, empty},   32'd1);
        check("rst_r_en",    {31'b0, r_en},    32'd0);
        check("rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("rst_m_data",  {24'b0, m_data},  32'd0);

        @(posedge clk_r); #1;
        arst_n  = 1'b1;
        m_ready = 1'b1;
        tick(2);

        // Single word: empty falls after two edges, one read, data two later.
        write_word(8'hA5);
        tick(1);
        check("single_empty_e1", {31'b0, empty}, 32'd1);
        tick(1);
        check("single_empty_e2", {31'b0, empty}, 32'd0);
        check("single_r_en",     {31'b0, r_en},  32'd1);
        tick(1);
        check("single_r_en_off", {31'b0, r_en},    32'd0);
        check("single_b_rptr",   {28'b0, b_rptr},  32'd1);
        check("single_g_rptr",   {28'b0, g_rptr},  32'd1);
        check("single_valid_e3", {31'b0, m_valid}, 32'd0);
        tick(1);
        check("single_valid",    {31'b0, m_valid}, 32'd1);
        check("single_data",     {24'b0, m_data},  32'hA5);
        tick(1);
        check("single_valid_end", {31'b0, m_valid}, 32'd0);
        check("single_empty_end", {31'b0, empty},   32'd1);

        // Streaming: eight back-to-back words give eight gapless beats.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    write_word(8'h10 + 8'(i));
                    tick(1);
                end
            end
            begin
                k = 0;
                while (!m_valid && k < 20) begin
                    @(negedge clk_r);
                    k++;
                end
                for (int i = 0; i < 8; i++) begin
                    check("stream_valid", {31'b0, m_valid}, 32'd1);
                    @(negedge clk_r);
                end
                check("stream_valid_end", {31'b0, m_valid}, 32'd0);
                check("stream_empty_end", {31'b0, empty},   32'd1);
            end
        join
        @(posedge clk_r); #1;
        check("stream_b_rptr", {28'b0, b_rptr}, 32'd9);

        // Backpressure: consumer stalled, five words available.
        m_ready  = 1'b0;
        base_cnt = r_en_count;
        base_b   = b_rptr;
        for (int i = 0; i < 5; i++) begin
            write_word(8'h40 + 8'(i));
            tick(1);
        end
        tick(6);
        check("bp_reads",   r_en_count - base_cnt, 32'd2);
        check("bp_b_rptr",  {28'b0, b_rptr}, {28'b0, base_b + 4'd2});
        check("bp_r_en",    {31'b0, r_en},    32'd0);
        check("bp_m_valid", {31'b0, m_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_data", {24'b0, m_data}, 32'h40);
            tick(1);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_r);
            check("bp_drain_valid", {31'b0, m_valid}, 32'd1);
        end
        @(negedge clk_r);
        check("bp_drain_end", {31'b0, m_valid}, 32'd0);
        @(posedge clk_r); #1;

        // Wrap: twenty more words carry the pointer from 14 through 15->0 to 2.
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 5; i++) begin
                write_word(8'h80 + 8'(b * 5 + i));
                tick(1);
            end
            wait_idle(40);
        end
        check("wrap_seen",   {31'b0, wrap_seen}, 32'd1);
        check("wrap_b_rptr", {28'b0, b_rptr},    32'd2);
        check("wrap_g_rptr", {28'b0, g_rptr},    32'd3);
        check("wrap_empty",  {31'b0, empty},     32'd1);

        // Asynchronous reset mid-transfer drops buffered and in-flight words.
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            write_word(8'hC0 + 8'(i));
            tick(1);
        end
        tick(3);
        #2;
        arst_n = 1'b0;
        exp_q.delete();
        wptr         = '0;
        g_wptr_async = '0;
        #1;
        check("mid_rst_b_rptr",  {28'b0, b_rptr},  32'd0);
        check("mid_rst_g_rptr",  {28'b0, g_rptr},  32'd0);
        check("mid_rst_empty",   {31'b0, empty},   32'd1);
        check("mid_rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("mid_rst_r_en",    {31'b0, r_en},    32'd0);
        @(posedge clk_r); #1;
        arst_n   = 1'b1;
        m_ready  = 1'b1;
        base_cnt = r_en_count;
        tick(4);
        check("post_rst_reads",   r_en_count - base_cnt, 32'd0);
        check("post_rst_m_valid", {31'b0, m_valid}, 32'd0);
        write_word(8'h5A);
        tick(1);
        wait_idle(20);
        check("post_rst_b_rptr", {28'b0, b_rptr}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
